// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the per-frame render/edit sequencer.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    RENDER,
    DRAIN,
    EDIT
  } state_t;

  localparam int POS_W   = 17;
  localparam int ANG_W   = 16;
  localparam int BADDR_W = 15;
  localparam int BID_W   = 5;

endpackage

// File: rtl/frame_sched_if.sv
// World-edit request handshake between an edit queue (master) and the sequencer (slave).
interface frame_sched_if;
  import frame_sched_pkg::*;

  logic               wr_req;
  logic [BADDR_W-1:0] wr_addr;
  logic [BID_W-1:0]   wr_data;
  logic               wr_ack;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);

endinterface

// File: rtl/frame_sched_vs_edge_det.sv
// Rising-edge detector for the (already synchronous) vsync input.
module vs_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_in,
  output logic vs_rise
);

  logic vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b0;
    else        vs_q <= vs_in;
  end

  assign vs_rise = vs_in & ~vs_q;

endmodule

// File: rtl/frame_sched.sv
// Per-frame sequencer: latch pose, start ppl, count pixels, drain, then open a map edit window.
// Optional RENDER watchdog enabled by defining FRAME_SCHED_WDOG_EN.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int H_DISP    = 16,
  parameter int V_DISP    = 12,
  parameter int DRAIN_CYC = 32,
  parameter int MAX_EDITS = 8
`ifdef FRAME_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC  = 65535
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vs_in,
  input  logic [POS_W-1:0]   pose_x,
  input  logic [POS_W-1:0]   pose_y,
  input  logic [POS_W-1:0]   pose_z,
  input  logic [ANG_W-1:0]   pose_ax,
  input  logic [ANG_W-1:0]   pose_ay,
  input  logic               ppl_valid,
  frame_sched_if.slave       wr,
  output logic               map_we,
  output logic [BADDR_W-1:0] map_waddr,
  output logic [BID_W-1:0]   map_wdata,
  output logic               ppl_start,
  output logic [POS_W-1:0]   p_pos_x,
  output logic [POS_W-1:0]   p_pos_y,
  output logic [POS_W-1:0]   p_pos_z,
  output logic [ANG_W-1:0]   p_angle_x,
  output logic [ANG_W-1:0]   p_angle_y,
  output logic               busy,
  output logic               overrun,
  output logic [15:0]        frame_cnt
);

  localparam int PIX_TOTAL = H_DISP * V_DISP;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam int EDIT_W    = $clog2(MAX_EDITS + 1);

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIX_TOTAL - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [EDIT_W-1:0]  EDIT_LAST  = EDIT_W'(MAX_EDITS - 1);

`ifdef FRAME_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_trip;
`endif

  state_t             state;
  logic               vs_rise;
  logic               wr_ack_q;
  logic [PIX_W-1:0]   pix_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [EDIT_W-1:0]  edit_cnt;

  vs_edge_det u_vs_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .vs_in   (vs_in),
    .vs_rise (vs_rise)
  );

  assign wr.wr_ack = wr_ack_q;
  assign map_we    = wr_ack_q;

  // A grant is never issued while the previous ack is still high: the requester
  // only replaces its request on the cycle after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ack_q  <= 1'b0;
      map_waddr <= '0;
      map_wdata <= '0;
      ppl_start <= 1'b0;
      p_pos_x   <= '0;
      p_pos_y   <= '0;
      p_pos_z   <= '0;
      p_angle_x <= '0;
      p_angle_y <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      pix_cnt   <= '0;
      drain_cnt <= '0;
      edit_cnt  <= '0;
`ifdef FRAME_SCHED_WDOG_EN
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
`endif
    end else begin
      ppl_start <= 1'b0;
      wr_ack_q  <= 1'b0;

      if (vs_rise && busy) overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (vs_rise) begin
            state <= LATCH;
            busy  <= 1'b1;
          end else if (wr.wr_req && !wr_ack_q) begin
            wr_ack_q  <= 1'b1;
            map_waddr <= wr.wr_addr;
            map_wdata <= wr.wr_data;
          end
        end

        LATCH: begin
          p_pos_x   <= pose_x;
          p_pos_y   <= pose_y;
          p_pos_z   <= pose_z;
          p_angle_x <= pose_ax;
          p_angle_y <= pose_ay;
          ppl_start <= 1'b1;
          pix_cnt   <= '0;
          state     <= RENDER;
`ifdef FRAME_SCHED_WDOG_EN
          wdog_cnt  <= '0;
          wdog_trip <= 1'b0;
`endif
        end

        RENDER: begin
          if (ppl_valid) pix_cnt <= pix_cnt + 1'b1;
          if (ppl_valid && pix_cnt == PIX_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
`ifdef FRAME_SCHED_WDOG_EN
          else if (wdog_cnt == WDOG_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            overrun   <= 1'b1;
            wdog_trip <= 1'b1;
          end
          wdog_cnt <= wdog_cnt + 1'b1;
`endif
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state    <= EDIT;
            busy     <= 1'b0;
            edit_cnt <= '0;
`ifdef FRAME_SCHED_WDOG_EN
            if (!wdog_trip) frame_cnt <= frame_cnt + 16'd1;
`else
            frame_cnt <= frame_cnt + 16'd1;
`endif
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        // A vsync here closes the window without being remembered as a frame start.
        EDIT: begin
          if (vs_rise) begin
            state <= IDLE;
          end else if (!wr_ack_q) begin
            if (wr.wr_req) begin
              wr_ack_q  <= 1'b1;
              map_waddr <= wr.wr_addr;
              map_wdata <= wr.wr_data;
              edit_cnt  <= edit_cnt + 1'b1;
              if (edit_cnt == EDIT_LAST) state <= IDLE;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: frame timing, pose hold, edit window, overrun, optional watchdog.
module tb_frame_sched;
  import frame_sched_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               vs_in;
  logic [POS_W-1:0]   pose_x, pose_y, pose_z;
  logic [ANG_W-1:0]   pose_ax, pose_ay;
  logic               ppl_valid;
  logic               map_we;
  logic [BADDR_W-1:0] map_waddr;
  logic [BID_W-1:0]   map_wdata;
  logic               ppl_start;
  logic [POS_W-1:0]   p_pos_x, p_pos_y, p_pos_z;
  logic [ANG_W-1:0]   p_angle_x, p_angle_y;
  logic               busy;
  logic               overrun;
  logic [15:0]        frame_cnt;

  frame_sched_if intf ();

  int checkCount = 0;
  int passCount  = 0;
  int reqTotal   = 0;
  int reqIdx     = 0;
  int ackCount   = 0;
  bit acked;

  frame_sched #(
    .H_DISP    (16),
    .V_DISP    (12),
    .DRAIN_CYC (32),
    .MAX_EDITS (8)
`ifdef FRAME_SCHED_WDOG_EN
    ,
    .WDOG_CYC  (500)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vs_in     (vs_in),
    .pose_x    (pose_x),
    .pose_y    (pose_y),
    .pose_z    (pose_z),
    .pose_ax   (pose_ax),
    .pose_ay   (pose_ay),
    .ppl_valid (ppl_valid),
    .wr        (intf.slave),
    .map_we    (map_we),
    .map_waddr (map_waddr),
    .map_wdata (map_wdata),
    .ppl_start (ppl_start),
    .p_pos_x   (p_pos_x),
    .p_pos_y   (p_pos_y),
    .p_pos_z   (p_pos_z),
    .p_angle_x (p_angle_x),
    .p_angle_y (p_angle_y),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BADDR_W-1:0] addrOf(int i);
    return BADDR_W'(32'h100 + i * 3);
  endfunction

  function automatic logic [BID_W-1:0] dataOf(int i);
    return BID_W'(i + 1);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel strobe per cycle for n cycles.
  task automatic applyStimulus(int n);
    for (int i = 0; i < n; i++) begin
      ppl_valid = 1'b1;
      tick();
    end
    ppl_valid = 1'b0;
  endtask

  // From IDLE: vsync pulse, LATCH cycle, then return in the first RENDER cycle.
  task automatic startFrame();
    vs_in = 1'b1;
    tick();
    checkOutput("latch_busy", 32'(busy), 32'd1);
    checkOutput("latch_no_start", 32'(ppl_start), 32'd0);
    vs_in = 1'b0;
    tick();
    checkOutput("ppl_start", 32'(ppl_start), 32'd1);
  endtask

  // Called in the first DRAIN cycle; returns in the first EDIT cycle.
  task automatic drainToEdit(int expFrames);
    repeat (31) tick();
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_frame_cnt", 32'(frame_cnt), 32'(expFrames - 1));
    tick();
    checkOutput("edit_not_busy", 32'(busy), 32'd0);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(expFrames));
  endtask

  // Edit-queue model: holds each request until acked, presents the next one a cycle later.
  initial begin
    intf.wr_req  = 1'b0;
    intf.wr_addr = '0;
    intf.wr_data = '0;
    forever begin
      @(negedge clk);
      acked = 1'b0;
      if (intf.wr_ack) begin
        checkOutput("ack_not_busy", 32'(busy), 32'd0);
        checkOutput("map_we", 32'(map_we), 32'd1);
        checkOutput("map_waddr", 32'(map_waddr), 32'(addrOf(reqIdx)));
        checkOutput("map_wdata", 32'(map_wdata), 32'(dataOf(reqIdx)));
        ackCount++;
        acked = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acked) reqIdx++;
      intf.wr_req  = (reqIdx < reqTotal);
      intf.wr_addr = addrOf(reqIdx);
      intf.wr_data = dataOf(reqIdx);
    end
  end

  initial begin
    rst_n = 1'b0; vs_in = 1'b0; ppl_valid = 1'b0;
    pose_x = 17'h12345; pose_y = 17'h00abc; pose_z = 17'h1ffff;
    pose_ax = 16'h1234; pose_ay = 16'hbeef;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_ppl_start", 32'(ppl_start), 32'd0);
    checkOutput("rst_map_we", 32'(map_we), 32'd0);
    checkOutput("rst_p_pos_x", 32'(p_pos_x), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Frame 1: pose A latched, pose B staged mid-frame must not leak through
    startFrame();
    checkOutput("f1_p_pos_x", 32'(p_pos_x), 32'h12345);
    checkOutput("f1_p_angle_y", 32'(p_angle_y), 32'hbeef);
    pose_x = 17'h0a5a5; pose_ay = 16'h0f0f;
    tick();
    checkOutput("start_one_cycle", 32'(ppl_start), 32'd0);
    applyStimulus(192);
    drainToEdit(1);
    checkOutput("f1_hold_p_pos_x", 32'(p_pos_x), 32'h12345);
    checkOutput("f1_hold_p_angle_y", 32'(p_angle_y), 32'hbeef);
    tick();
    tick();

    // Frame 2: 12 edits queued during RENDER; 8 in EDIT, 4 in IDLE
    startFrame();
    checkOutput("f2_p_pos_x", 32'(p_pos_x), 32'h0a5a5);
    checkOutput("f2_p_angle_y", 32'(p_angle_y), 32'h0f0f);
    reqTotal = 12;
    applyStimulus(192);
    drainToEdit(2);
    checkOutput("f2_acks_before_edit", 32'(ackCount), 32'd0);
    repeat (16) tick();
    checkOutput("f2_acks_window", 32'(ackCount), 32'd8);
    repeat (10) tick();
    checkOutput("f2_acks_total", 32'(ackCount), 32'd12);
    checkOutput("f2_req_drained", 32'(intf.wr_req), 32'd0);

    // Frame 3: extra vsync at pixel 100 -> overrun, no restart or relatch
    startFrame();
    checkOutput("f3_overrun_clear", 32'(overrun), 32'd0);
    pose_x = 17'h1c3c3;
    applyStimulus(100);
    vs_in = 1'b1;
    applyStimulus(1);
    vs_in = 1'b0;
    checkOutput("f3_overrun", 32'(overrun), 32'd1);
    checkOutput("f3_still_busy", 32'(busy), 32'd1);
    checkOutput("f3_no_restart", 32'(ppl_start), 32'd0);
    checkOutput("f3_no_relatch", 32'(p_pos_x), 32'h0a5a5);
    applyStimulus(91);
    drainToEdit(3);
    tick();
    tick();

    // Frame 4: edit cap closes the window, so a vsync right after the 8th ack starts a frame
    startFrame();
    checkOutput("f4_p_pos_x", 32'(p_pos_x), 32'h1c3c3);
    reqTotal = 24;
    applyStimulus(192);
    drainToEdit(4);
    repeat (15) tick();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    checkOutput("f4_cap_then_latch", 32'(busy), 32'd1);
    checkOutput("f4_acks", 32'(ackCount), 32'd20);
    tick();
    checkOutput("f4_ppl_start", 32'(ppl_start), 32'd1);

    // Frame 5: vsync inside EDIT drops to IDLE without starting a frame
    applyStimulus(192);
    drainToEdit(5);
    tick();
    tick();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    checkOutput("f5_vs_in_edit_idle", 32'(busy), 32'd0);
    checkOutput("f5_acks_mid", 32'(ackCount), 32'd21);
    repeat (7) tick();
    checkOutput("f5_acks_total", 32'(ackCount), 32'd24);
    checkOutput("f5_overrun_sticky", 32'(overrun), 32'd1);

`ifdef FRAME_SCHED_WDOG_EN
    // Watchdog: 50 pixels only; DRAIN forced after 500 RENDER cycles, frame not counted
    tick();
    startFrame();
    applyStimulus(50);
    repeat (481) tick();
    checkOutput("wdog_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("wdog_done", 32'(busy), 32'd0);
    checkOutput("wdog_frame_cnt", 32'(frame_cnt), 32'd5);
    checkOutput("wdog_overrun", 32'(overrun), 32'd1);
`endif

    tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
